// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared types and constants for the mycpu control path
package mycpu_pkg;

    typedef enum logic [2:0] {
        RST,
        INF,
        EX0,
        SHF,
        HLT
    } cu_mc_state_t;

    // ALU opcodes share their low nibble with the function-select code
    typedef enum logic [6:0] {
        OP_MOVA = 7'h00, OP_INC, OP_ADD, OP_MUL,
        OP_SRA,  OP_SUB, OP_DEC, OP_SLA,
        OP_AND,  OP_OR,  OP_XOR, OP_NOT,
        OP_MOVB, OP_SHR, OP_SHL, OP_CLR,
        OP_LDI  = 7'h10, OP_ADI, OP_LD, OP_ST,
        OP_IOR,  OP_IOW, OP_BRZ, OP_BRN,
        OP_JMP,  OP_HAL, OP_SHLN, OP_SHRN
    } opcode_t;

    typedef enum logic [3:0] {
        FS_MOVA = 4'h0, FS_INC, FS_ADD, FS_MUL,
        FS_SRA,  FS_SUB, FS_DEC, FS_SLA,
        FS_AND,  FS_OR,  FS_XOR, FS_NOT,
        FS_MOVB, FS_SHR, FS_SHL, FS_CLR
    } fs_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [1:0] MD_FU  = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_IO  = 2'b10;

endpackage

// File: rtl/cu_mc.sv
// rtl/cu_mc.sv - multi-cycle control unit with ready handshake and counted shifts
module cu_mc
    import mycpu_pkg::*;
#(
    parameter int RAW = 3,
    parameter int IW  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IW-1:0]          ins_in,
    input  logic                   z_in,
    input  logic                   n_in,
    input  logic                   mem_rdy_in,
    output logic                   il_out,
    output logic [1:0]             ps_out,
    output logic                   rw_out,
    output logic [3*(RAW+1)-1:0]   rs_out,
    output logic                   mm_out,
    output logic [1:0]             md_out,
    output logic                   mb_out,
    output logic [3:0]             fs_out,
    output logic                   wen_out,
    output logic                   iom_out,
    output logic                   halt_out,
    output logic                   err_out
);

    localparam int OPW = IW - 3*RAW;
    localparam logic [RAW-1:0] ONE = 1;

    cu_mc_state_t state, state_nxt;
    logic [RAW-1:0] cnt, cnt_nxt;
    logic           err_nxt;

    logic [OPW-1:0] op;
    logic [6:0]     op7;
    logic           op_hi_zero;
    logic [RAW-1:0] da, aa, ba;

    assign op         = ins_in[IW-1:3*RAW];
    assign op7        = op[6:0];
    assign op_hi_zero = ((op >> 7) == '0);
    assign da         = ins_in[3*RAW-1:2*RAW];
    assign aa         = ins_in[2*RAW-1:RAW];
    assign ba         = ins_in[RAW-1:0];

    function automatic logic [3*(RAW+1)-1:0] build_rs(input logic [RAW-1:0] d,
                                                      input logic [RAW-1:0] a,
                                                      input logic [RAW-1:0] b);
        return {1'b0, d, 1'b0, a, 1'b0, b};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST;
            cnt     <= '0;
            err_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            err_out <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_out;
        il_out    = 1'b0;
        ps_out    = PS_HOLD;
        rw_out    = 1'b0;
        rs_out    = '0;
        mm_out    = 1'b0;
        md_out    = MD_FU;
        mb_out    = 1'b0;
        fs_out    = FS_MOVA;
        wen_out   = 1'b1;
        iom_out   = 1'b0;
        halt_out  = 1'b0;

        case (state)
            RST: begin
                cnt_nxt   = '0;
                state_nxt = INF;
            end
            INF: begin
                mm_out = 1'b1;
                if (mem_rdy_in) begin
                    il_out    = 1'b1;
                    state_nxt = EX0;
                end
            end
            EX0: begin
                rs_out = build_rs(da, aa, ba);
                if (!op_hi_zero) begin
                    rs_out    = '0;
                    err_nxt   = 1'b1;
                    state_nxt = HLT;
                end else if (op7 < 7'h10) begin
                    fs_out    = op7[3:0];
                    rw_out    = 1'b1;
                    ps_out    = PS_INC;
                    state_nxt = INF;
                end else begin
                    case (op7)
                        OP_LDI, OP_ADI: begin
                            fs_out    = (op7 == OP_LDI) ? FS_MOVB : FS_ADD;
                            mb_out    = 1'b1;
                            rw_out    = 1'b1;
                            ps_out    = PS_INC;
                            state_nxt = INF;
                        end
                        OP_LD, OP_ST, OP_IOR, OP_IOW: begin
                            md_out  = (op7 == OP_LD) ? MD_MEM : (op7 == OP_IOR) ? MD_IO : MD_FU;
                            wen_out = !(op7 == OP_ST || op7 == OP_IOW);
                            iom_out = (op7 == OP_IOR || op7 == OP_IOW);
                            if (mem_rdy_in) begin
                                rw_out    = (op7 == OP_LD || op7 == OP_IOR);
                                ps_out    = PS_INC;
                                state_nxt = INF;
                            end
                        end
                        OP_BRZ, OP_BRN: begin
                            md_out    = MD_MEM;
                            ps_out    = ((op7 == OP_BRZ) ? z_in : n_in) ? PS_BR : PS_INC;
                            state_nxt = INF;
                        end
                        OP_JMP: begin
                            ps_out    = PS_JMP;
                            state_nxt = INF;
                        end
                        OP_HAL: begin
                            rs_out    = '0;
                            state_nxt = HLT;
                        end
                        OP_SHLN, OP_SHRN: begin
                            rw_out = 1'b1;
                            if (ba == '0) begin
                                fs_out    = FS_MOVA;
                                ps_out    = PS_INC;
                                state_nxt = INF;
                            end else begin
                                fs_out  = (op7 == OP_SHLN) ? FS_SHL : FS_SHR;
                                cnt_nxt = ba - ONE;
                                if (ba == ONE) begin
                                    ps_out    = PS_INC;
                                    state_nxt = INF;
                                end else begin
                                    state_nxt = SHF;
                                end
                            end
                        end
                        default: begin
                            rs_out    = '0;
                            err_nxt   = 1'b1;
                            state_nxt = HLT;
                        end
                    endcase
                end
            end
            SHF: begin
                // later passes shift the destination in place
                rs_out  = build_rs(da, da, ba);
                rw_out  = 1'b1;
                fs_out  = (op7 == OP_SHRN) ? FS_SHR : FS_SHL;
                cnt_nxt = cnt - ONE;
                if (cnt == ONE) begin
                    ps_out    = PS_INC;
                    state_nxt = INF;
                end
            end
            HLT: begin
                halt_out = 1'b1;
            end
            default: state_nxt = RST;
        endcase
    end

endmodule

// File: doc/cu_mc.md
# cu_mc

Parametrised multi-cycle control unit for the mycpu datapath; next generation of the single-cycle-execute CU. It decodes the instruction register and drives program-counter, register-file, function-unit, memory and I/O control. Compared with the current CU it adds:
- generic instruction/register-address widths;
- a memory/I/O ready handshake that stretches fetch and load/store/IO cycles;
- counted multi-bit shift instructions (SHLN/SHRN) executed by an internal loop counter;
- sticky halt and illegal-opcode status outputs.

## Interface
- RAW, 3: register address width; register file has 2**RAW entries.
- IW, 16: instruction width; opcode field is ins_in[IW-1:3*RAW], which must be ≥ 7 bits.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- ins_in  in  IW  instruction register contents: opcode, DA=[3*RAW-1:2*RAW], AA=[2*RAW-1:RAW], BA=[RAW-1:0].
- z_in, n_in  in  1 each  zero/negative flags from the function unit.
- mem_rdy_in  in  1  memory/I/O access completes this cycle.
- il_out  out  1  instruction load.
- ps_out  out  2  PC control: 00 hold, 01 increment, 10 branch, 11 jump.
- rw_out  out  1  register write.
- rs_out  out  3*(RAW+1)  {0,DA,0,AA,0,BA}.
- mm_out  out  1  memory address from PC.
- md_out  out  2  write-back mux: 00 FU, 01 memory, 10 I/O.
- mb_out  out  1  constant operand select.
- fs_out  out  4  function select.
- wen_out  out  1  memory/I/O write enable, active-low.
- iom_out  out  1  I/O space select.
- halt_out  out  1  core halted.
- err_out  out  1  sticky illegal opcode.

## Operation
- States: RST, INF, EX0, SHF, HLT (cu_mc_state_t).
- **Idle vector:** ps 00, il 0, rw 0, rs 0, mm 0, md 00, mb 0, fs 0000, wen 1, iom 0.
- **Reset:** asynchronous to RST. RST drives the idle vector with halt_out=0 and err_out=0, then goes to INF.
- **INF:** mm=1. il=1 only in a cycle with mem_rdy_in=1, then go to EX0. Otherwise stay in INF with il=0.
- **EX0, ALU ops:** rw=1, ps=01, go to INF. fs by opcode:
  - MOVA 0000, INC 0001, ADD 0010, MUL 0011
  - SRA 0100, SUB 0101, DEC 0110, SLA 0111
  - AND 1000, OR 1001, XOR 1010, NOT 1011
  - MOVB 1100, SHR 1101, SHL 1110, CLR 1111
- **LDI / ADI:** as MOVB / ADD with mb=1.
- **LD / ST / IOR / IOW:** wait on mem_rdy_in, staying in EX0 with ps=00 while it is low.
  - LD: md=01.
  - ST: wen=0 held every waiting cycle.
  - IOR: md=10, iom=1.
  - IOW: wen=0, iom=1.
  - rw=1 (LD, IOR) and ps=01 are asserted only in the cycle mem_rdy_in=1; go to INF after that cycle.
- **BRZ / BRN:** ps=10 if z_in / n_in is set, else 01; md=01, rw=0.
- **JMP:** ps=11.
- **SHLN / SHRN** (fs 1110 / 1101):
  - The count is the BA field.
  - count=0: behaves as MOVA.
  - Otherwise EX0 performs the first shift (rs={0,DA,0,AA,0,BA}, rw=1) and loads cnt=count-1.
  - If cnt=0, ps=01 and go to INF; else go to SHF.
  - SHF: rs={0,DA,0,DA,0,BA}, rw=1, ps=00, cnt decrements. When cnt=1, ps=01 and go to INF.
- **HAL:** go to HLT.
- **Unrecognised opcode:** set err_out and go to HLT.
- **HLT:** idle vector, halt_out=1. Left only by reset.

## Timing
- INF and EX0 are Moore/Mealy mixed: all outputs are combinational from state, ins_in, flags and mem_rdy_in.
- Registered: state, cnt (RAW bits), err_out.
- Instruction latency in cycles, with mem_rdy_in tied high:
  - ALU, branch, LD/ST: 2.
  - Each low mem_rdy_in cycle adds 1.
  - SHLN/SHRN: 1+max(count,1).
- halt_out asserts the cycle after HAL or illegal decode.
- Reset mid-SHF or mid-wait: abandon immediately, clear cnt.
- ins_in must be stable from il until the instruction leaves EX0/SHF.

## Structure
- Add to mycpu_pkg:
  - cu_mc_state_t.
  - opcode_t extended with SHLN and SHRN.
  - fs_t constants matching the encodings above.
  - PS_HOLD/INC/BR/JMP constants.
- Single module. One internal function builds rs_out from DA/AA/BA; no sub-module.

## Test plan
- **Reset and fetch:** reset, mem_rdy_in low 3 cycles then high → INF held 3 cycles with il=0, mm=1; il=1 on cycle 4; halt_out=0 and err_out=0 throughout.
- **ADD then LDI:** ADD DA=2,AA=3,BA=4 → rs=0x234, fs=0010, rw=1, ps=01. LDI DA=1 → mb=1, fs=1100.
- **ST with 2-cycle wait:** wen=0 and ps=00 for 2 cycles, then wen=0 and ps=01 on the ready cycle, rw=0, then INF.
- **BRZ:** z_in=1 → ps=10. z_in=0 → ps=01.
- **SHLN DA=5,AA=6,BA=3:** 3 execute cycles with fs=1110, rw=1; rs=0x563, then 0x553, 0x553; ps=01 only on the last cycle. Repeat with BA=0 → single MOVA cycle with fs=0000.
- **Illegal opcode:** err_out=1 and halt_out=1 stay set, outputs idle, until rst_n pulse clears both. HAL sets halt_out with err_out=0.
